// File: rtl/stateful_rmw.sv
// Stateful read-modify-write atom: per-flow state register file updated by one packet
// per cycle, returning the old and new entry values two cycles after the packet arrives.
module stateful_rmw #(
  parameter int COUNT_WIDTH = 32,
  parameter int NUM_REGS    = 16,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [IDX_WIDTH-1:0]   i_idx,
  input  logic [COUNT_WIDTH-1:0] pkt_1,
  input  logic [COUNT_WIDTH-1:0] cons_1,
  input  logic [2:0]             opcode,
  output logic                   o_valid,
  output logic [COUNT_WIDTH-1:0] o_old,
  output logic [COUNT_WIDTH-1:0] o_new
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_SET  = 3'd2,
    OP_WRAP = 3'd3,
    OP_READ = 3'd4
  } op_e;

  logic [COUNT_WIDTH-1:0] r_mem [NUM_REGS];

  logic                   r_s1Valid;
  logic [IDX_WIDTH-1:0]   r_s1Idx;
  logic [COUNT_WIDTH-1:0] r_s1Pkt;
  logic [COUNT_WIDTH-1:0] r_s1Cons;
  logic [2:0]             r_s1Op;
  logic [COUNT_WIDTH-1:0] r_s1Rdata;

  logic                   r_s2Valid;
  logic [IDX_WIDTH-1:0]   r_s2Idx;
  logic [COUNT_WIDTH-1:0] r_s2Old;
  logic [COUNT_WIDTH-1:0] r_s2New;
  logic                   r_s2Wrote;

  logic                   w_bypass;
  logic [COUNT_WIDTH-1:0] w_cur;
  logic [COUNT_WIDTH-1:0] w_new;
  logic                   w_writes;
  logic                   w_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Idx   <= '0;
      r_s1Pkt   <= '0;
      r_s1Cons  <= '0;
      r_s1Op    <= OP_READ;
      r_s1Rdata <= '0;
    end else begin
      r_s1Valid <= i_valid;
      if (i_valid) begin
        r_s1Idx   <= i_idx;
        r_s1Pkt   <= pkt_1;
        r_s1Cons  <= cons_1;
        r_s1Op    <= opcode;
        r_s1Rdata <= r_mem[i_idx];
      end
    end
  end

  // A same-cycle write to the entry being read lands after the read, so the stale
  // value is replaced here by the result of the packet one stage ahead.
  always_comb begin
    w_bypass = r_s2Valid && r_s2Wrote && (r_s2Idx == r_s1Idx);
    w_cur    = w_bypass ? r_s2New : r_s1Rdata;
  end

  always_comb begin
    w_new    = w_cur;
    w_writes = 1'b1;
    case (r_s1Op)
      OP_ADD:  w_new = w_cur + r_s1Pkt;
      OP_SUB:  w_new = w_cur - r_s1Pkt;
      OP_SET:  w_new = r_s1Pkt;
      OP_WRAP: w_new = (w_cur >= r_s1Cons) ? '0 : w_cur + r_s1Pkt;
      default: begin
        w_new    = w_cur;
        w_writes = 1'b0;
      end
    endcase
    w_write = r_s1Valid && w_writes;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_write) begin
      r_mem[r_s1Idx] <= w_new;
    end
  end

  // Result values only advance on valid packets so the outputs hold across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2Valid <= 1'b0;
      r_s2Idx   <= '0;
      r_s2Old   <= '0;
      r_s2New   <= '0;
      r_s2Wrote <= 1'b0;
    end else begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Idx   <= r_s1Idx;
        r_s2Old   <= w_cur;
        r_s2New   <= w_new;
        r_s2Wrote <= w_writes;
      end
    end
  end

  always_comb begin
    o_valid = r_s2Valid;
    o_old   = r_s2Old;
    o_new   = r_s2New;
  end

endmodule

// File: tb/tb_stateful_rmw.sv
// Self-checking bench for stateful_rmw: directed scenarios plus random traffic checked
// against an in-order array model of the state entries.
module tb_stateful_rmw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [3:0]  i_idx = '0;
  logic [31:0] pkt_1 = '0;
  logic [31:0] cons_1 = '0;
  logic [2:0]  opcode = 3'd4;
  logic        o_valid;
  logic [31:0] o_old;
  logic [31:0] o_new;

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0] modelMem [16];
  logic        lineV [2];
  logic [31:0] lineOld [2];
  logic [31:0] lineNew [2];
  logic [31:0] lastOld, lastNew;
  logic        expV;
  logic [31:0] expOld, expNew;

  stateful_rmw #(.COUNT_WIDTH(32), .NUM_REGS(16), .IDX_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_idx(i_idx), .pkt_1(pkt_1),
    .cons_1(cons_1), .opcode(opcode), .o_valid(o_valid), .o_old(o_old), .o_new(o_new)
  );

  always #5 clk = ~clk;

  // Packets are applied to the model in arrival order, which is the ordering the
  // hardware must be indistinguishable from.
  function automatic void modelApply(input logic [3:0] idx, input logic [31:0] p,
                                     input logic [31:0] c, input logic [2:0] op,
                                     output logic [31:0] oldV, output logic [31:0] newV);
    oldV = modelMem[idx];
    case (op)
      3'd0:    newV = oldV + p;
      3'd1:    newV = oldV - p;
      3'd2:    newV = p;
      3'd3:    newV = (oldV >= c) ? 32'd0 : oldV + p;
      default: newV = oldV;
    endcase
    if (op <= 3'd3) modelMem[idx] = newV;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 16; i++) modelMem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      lineV[i] = 1'b0; lineOld[i] = '0; lineNew[i] = '0;
    end
    lastOld = '0; lastNew = '0;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelClear();
  endtask

  // At each falling edge the outputs belong to the packet driven two edges earlier.
  task automatic tick(input logic v, input logic [3:0] idx, input logic [31:0] p,
                      input logic [31:0] c, input logic [2:0] op);
    logic [31:0] ov, nv;
    @(negedge clk);
    expV = lineV[1]; expOld = lineOld[1]; expNew = lineNew[1];
    lineV[1] = lineV[0]; lineOld[1] = lineOld[0]; lineNew[1] = lineNew[0];
    if (v) begin
      modelApply(idx, p, c, op, ov, nv);
      lastOld = ov; lastNew = nv;
    end
    lineV[0] = v; lineOld[0] = lastOld; lineNew[0] = lastNew;
    i_valid = v; i_idx = idx; pkt_1 = p; cons_1 = c; opcode = op;
  endtask

  task automatic test_reset();
    doReset();
    @(negedge clk);
    testsRun++;
    if ({o_valid, o_old, o_new} !== 65'd0)
      begin testsFailed++; $display("[TB] FAIL reset_outputs got v=%0b old=%h new=%h want all 0", o_valid, o_old, o_new); end
    for (int i = 0; i < 18; i++) begin
      if (i < 16) tick(1'b1, 4'(i), $urandom, $urandom, 3'd4);
      else        tick(1'b0, 4'd0, 32'd0, 32'd0, 3'd4);
      testsRun++;
      if (o_valid !== (i >= 2) || o_old !== 32'd0 || o_new !== 32'd0)
        begin testsFailed++; $display("[TB] FAIL reset_read step=%0d got v=%0b old=%h new=%h want v=%0b old=0 new=0", i, o_valid, o_old, o_new, (i >= 2)); end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] gotOld[$], gotNew[$];
    logic [31:0] wantOld [4] = '{32'd0, 32'd5, 32'd10, 32'd15};
    logic [31:0] wantNew [4] = '{32'd5, 32'd10, 32'd15, 32'd20};
    doReset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) tick(1'b1, 4'd3, 32'd5, 32'd0, 3'd0);
      else       tick(1'b0, 4'd3, 32'd0, 32'd0, 3'd4);
      testsRun++;
      if ({o_valid, o_old, o_new} !== {expV, expOld, expNew})
        begin testsFailed++; $display("[TB] FAIL bypass_model step=%0d got v=%0b old=%h new=%h want v=%0b old=%h new=%h", i, o_valid, o_old, o_new, expV, expOld, expNew); end
      if (o_valid === 1'b1) begin gotOld.push_back(o_old); gotNew.push_back(o_new); end
    end
    for (int k = 0; k < 4; k++) begin
      testsRun++;
      if (k >= gotNew.size() || gotOld[k] !== wantOld[k] || gotNew[k] !== wantNew[k])
        begin testsFailed++; $display("[TB] FAIL bypass_const k=%0d got %0d results want old=%0d new=%0d", k, gotNew.size(), wantOld[k], wantNew[k]); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] gotNew[$];
    logic [31:0] wantNew [5] = '{32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
    doReset();
    for (int i = 0; i < 7; i++) begin
      if (i < 5) tick(1'b1, 4'd7, 32'd1, 32'd2, 3'd3);
      else       tick(1'b0, 4'd7, 32'd0, 32'd0, 3'd4);
      testsRun++;
      if ({o_valid, o_old, o_new} !== {expV, expOld, expNew})
        begin testsFailed++; $display("[TB] FAIL wrap_model step=%0d got v=%0b old=%h new=%h want v=%0b old=%h new=%h", i, o_valid, o_old, o_new, expV, expOld, expNew); end
      if (o_valid === 1'b1) gotNew.push_back(o_new);
    end
    for (int k = 0; k < 5; k++) begin
      testsRun++;
      if (k >= gotNew.size() || gotNew[k] !== wantNew[k])
        begin testsFailed++; $display("[TB] FAIL wrap_const k=%0d got %0d results want new=%0d", k, gotNew.size(), wantNew[k]); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] gotNew[$];
    logic [31:0] wantNew [3] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
    doReset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       tick(1'b1, 4'd1, 32'hFFFF_FFFF, 32'd0, 3'd2);
        1:       tick(1'b1, 4'd1, 32'd1, 32'd0, 3'd0);
        2:       tick(1'b1, 4'd1, 32'd1, 32'd0, 3'd1);
        default: tick(1'b0, 4'd1, 32'd0, 32'd0, 3'd4);
      endcase
      testsRun++;
      if ({o_valid, o_old, o_new} !== {expV, expOld, expNew})
        begin testsFailed++; $display("[TB] FAIL overflow_model step=%0d got v=%0b old=%h new=%h want v=%0b old=%h new=%h", i, o_valid, o_old, o_new, expV, expOld, expNew); end
      if (o_valid === 1'b1) gotNew.push_back(o_new);
    end
    for (int k = 0; k < 3; k++) begin
      testsRun++;
      if (k >= gotNew.size() || gotNew[k] !== wantNew[k])
        begin testsFailed++; $display("[TB] FAIL overflow_const k=%0d got %0d results want new=%h", k, gotNew.size(), wantNew[k]); end
    end
  endtask

  task automatic test_interleave();
    logic [31:0] gotNew[$];
    logic [3:0]  seqIdx [6] = '{4'd2, 4'd5, 4'd2, 4'd5, 4'd2, 4'd5};
    logic [31:0] wantNew [6] = '{32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2};
    doReset();
    for (int i = 0; i < 8; i++) begin
      if (i < 4)      tick(1'b1, seqIdx[i], 32'd1, 32'd0, 3'd0);
      else if (i < 6) tick(1'b1, seqIdx[i], 32'd9, 32'd0, 3'd4);
      else            tick(1'b0, 4'd0, 32'd0, 32'd0, 3'd4);
      testsRun++;
      if ({o_valid, o_old, o_new} !== {expV, expOld, expNew})
        begin testsFailed++; $display("[TB] FAIL interleave_model step=%0d got v=%0b old=%h new=%h want v=%0b old=%h new=%h", i, o_valid, o_old, o_new, expV, expOld, expNew); end
      if (o_valid === 1'b1) gotNew.push_back(o_new);
    end
    for (int k = 0; k < 6; k++) begin
      testsRun++;
      if (k >= gotNew.size() || gotNew[k] !== wantNew[k])
        begin testsFailed++; $display("[TB] FAIL interleave_const k=%0d got %0d results want new=%0d", k, gotNew.size(), wantNew[k]); end
    end
  endtask

  task automatic test_reset_inflight();
    doReset();
    tick(1'b1, 4'd0, 32'd7, 32'd0, 3'd0);
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({o_valid, o_old, o_new} !== 65'd0)
      begin testsFailed++; $display("[TB] FAIL inflight_drop got v=%0b old=%h new=%h want all 0", o_valid, o_old, o_new); end
    rst = 1'b0;
    modelClear();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) tick(1'b1, 4'd0, 32'd0, 32'd0, 3'd4);
      else        tick(1'b0, 4'd0, 32'd0, 32'd0, 3'd4);
      testsRun++;
      if (o_valid !== (i == 2) || o_old !== 32'd0 || o_new !== 32'd0)
        begin testsFailed++; $display("[TB] FAIL inflight_read step=%0d got v=%0b old=%h new=%h want v=%0b old=0 new=0", i, o_valid, o_old, o_new, (i == 2)); end
    end
  endtask

  task automatic test_random();
    logic        v;
    logic [3:0]  idx;
    logic [31:0] p, c;
    logic [2:0]  op;
    doReset();
    for (int i = 0; i < 600; i++) begin
      if (i < 598) begin
        v   = ($urandom_range(0, 3) != 0);
        idx = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
        p   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
        c   = 32'($urandom_range(0, 20));
        op  = 3'($urandom);
      end else begin
        v = 1'b0; idx = 4'($urandom); p = $urandom; c = $urandom; op = 3'($urandom);
      end
      tick(v, idx, p, c, op);
      testsRun++;
      if ({o_valid, o_old, o_new} !== {expV, expOld, expNew})
        begin testsFailed++; $display("[TB] FAIL random step=%0d got v=%0b old=%h new=%h want v=%0b old=%h new=%h", i, o_valid, o_old, o_new, expV, expOld, expNew); end
    end
  endtask

  initial begin
    modelClear();
    test_reset();
    test_bypass();
    test_wrap();
    test_overflow();
    test_interleave();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
